// File: rtl/pipelined_main_control_pkg.sv
// Shared opcode map, ALU-class encoding and per-stage control bundles
// for the pipelined MIPS main control.
package main_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Full 3-bit ALU class; the basic variant only ever produces codes < 4.
  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_SUB   = 3'b001;
  localparam logic [2:0] ULA_FUNCT = 3'b010;
  localparam logic [2:0] ULA_AND   = 3'b011;
  localparam logic [2:0] ULA_OR    = 3'b100;
  localparam logic [2:0] ULA_SLT   = 3'b101;

  typedef struct packed {
    logic       regdst;
    logic       ULAsrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       bne;
    logic       jump;
    logic [2:0] ULAop;
  } ctrl_t;

  // Controls still needed once the instruction has left EX.
  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic bne;
  } mem_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  localparam ctrl_t     CTRL_BUBBLE = '0;
  localparam mem_ctrl_t MEM_BUBBLE  = '0;
  localparam wb_ctrl_t  WB_BUBBLE   = '0;

  function automatic mem_ctrl_t to_mem(input ctrl_t c);
    mem_ctrl_t m;
    m.memtoreg = c.memtoreg;
    m.regwrite = c.regwrite;
    m.memread  = c.memread;
    m.memwrite = c.memwrite;
    m.branch   = c.branch;
    m.bne      = c.bne;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
    wb_ctrl_t w;
    w.memtoreg = m.memtoreg;
    w.regwrite = m.regwrite;
    return w;
  endfunction

endpackage

// File: rtl/pipelined_main_control_decoder.sv
// Combinational opcode decoder: op -> control bundle, flagging opcodes
// outside the enabled instruction set.
module control_decoder
  import main_control_pkg::*;
#(
  parameter bit EXT = 1'b1
) (
  input  logic [5:0] op,
  output ctrl_t      ctrl,
  output logic       illegal_op
);

  always_comb begin
    ctrl       = CTRL_BUBBLE;
    illegal_op = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.ULAop    = ULA_FUNCT;
      end
      OP_LW: begin
        ctrl.ULAsrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.ULAop    = ULA_ADD;
      end
      OP_SW: begin
        ctrl.ULAsrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.ULAop    = ULA_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.ULAop  = ULA_SUB;
      end
      // Extended opcodes fall back to illegal when the variant lacks them.
      OP_BNE: begin
        if (EXT) begin
          ctrl.branch = 1'b1;
          ctrl.bne    = 1'b1;
          ctrl.ULAop  = ULA_SUB;
        end else begin
          illegal_op = 1'b1;
        end
      end
      OP_ADDI: begin
        if (EXT) begin
          ctrl.ULAsrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.ULAop    = ULA_ADD;
        end else begin
          illegal_op = 1'b1;
        end
      end
      OP_ANDI: begin
        if (EXT) begin
          ctrl.ULAsrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.ULAop    = ULA_AND;
        end else begin
          illegal_op = 1'b1;
        end
      end
      OP_ORI: begin
        if (EXT) begin
          ctrl.ULAsrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.ULAop    = ULA_OR;
        end else begin
          illegal_op = 1'b1;
        end
      end
      OP_SLTI: begin
        if (EXT) begin
          ctrl.ULAsrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.ULAop    = ULA_SLT;
        end else begin
          illegal_op = 1'b1;
        end
      end
      OP_J: begin
        if (EXT) begin
          ctrl.jump = 1'b1;
        end else begin
          illegal_op = 1'b1;
        end
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_main_control.sv
// Pipelined main control: decodes the ID opcode and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, with bubble/squash and illegal-op counting.
module pipelined_main_control
  import main_control_pkg::*;
#(
  parameter bit EXT  = 1'b1,
  parameter int CNTW = 8,
  localparam int ULAOPW = EXT ? 3 : 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_regdst,
  output logic              ex_ULAsrc,
  output logic              ex_branch,
  output logic              ex_bne,
  output logic              ex_jump,
  output logic [ULAOPW-1:0] ex_ULAop,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_branch,
  output logic              mem_bne,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic              illegal,
  output logic [CNTW-1:0]   illegal_cnt
);

  // id_valid qualifies op for exactly the cycle it is high; there is no
  // backpressure, stall and flush only replace the ID/EX (and EX/MEM) load.
  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  ctrl_t           id_ex_d;
  logic            illegal_accept;
  ctrl_t           id_ex;
  mem_ctrl_t       ex_mem;
  wb_ctrl_t        mem_wb;
  logic            illegal_q;
  logic [CNTW-1:0] cnt_q;

  control_decoder #(.EXT(EXT)) u_decoder (
    .op         (op),
    .ctrl       (dec_ctrl),
    .illegal_op (dec_illegal)
  );

  // A squashed or stalled slot never reports an illegal opcode.
  assign illegal_accept = id_valid && dec_illegal && !flush && !stall;

  always_comb begin
    id_ex_d = dec_ctrl;
    if (flush || stall || !id_valid || dec_illegal) begin
      id_ex_d = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex     <= CTRL_BUBBLE;
      ex_mem    <= MEM_BUBBLE;
      mem_wb    <= WB_BUBBLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      id_ex     <= id_ex_d;
      ex_mem    <= flush ? MEM_BUBBLE : to_mem(id_ex);
      mem_wb    <= to_wb(ex_mem);
      illegal_q <= illegal_accept;
      if (illegal_accept && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign ex_regdst    = id_ex.regdst;
  assign ex_ULAsrc    = id_ex.ULAsrc;
  assign ex_branch    = id_ex.branch;
  assign ex_bne       = id_ex.bne;
  assign ex_jump      = id_ex.jump;
  assign ex_ULAop     = id_ex.ULAop[ULAOPW-1:0];
  assign mem_memread  = ex_mem.memread;
  assign mem_memwrite = ex_mem.memwrite;
  assign mem_branch   = ex_mem.branch;
  assign mem_bne      = ex_mem.bne;
  assign wb_memtoreg  = mem_wb.memtoreg;
  assign wb_regwrite  = mem_wb.regwrite;
  assign illegal      = illegal_q;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_pipelined_main_control.sv
// Scoreboard bench for pipelined_main_control: drives an extended and a
// basic instance with the same directed opcode stream.
module tb_pipelined_main_control;

  localparam int OW = 23;
  localparam int W  = 2 * OW;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       id_valid;
  logic       stall;
  logic       flush;

  logic       x1_regdst, x1_ulasrc, x1_branch, x1_bne, x1_jump;
  logic [2:0] x1_ulaop;
  logic       m1_memread, m1_memwrite, m1_branch, m1_bne, w1_memtoreg, w1_regwrite, i1_illegal;
  logic [7:0] c1_cnt;

  logic       x0_regdst, x0_ulasrc, x0_branch, x0_bne, x0_jump;
  logic [1:0] x0_ulaop;
  logic       m0_memread, m0_memwrite, m0_branch, m0_bne, w0_memtoreg, w0_regwrite, i0_illegal;
  logic [7:0] c0_cnt;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipelined_main_control #(.EXT(1'b1), .CNTW(8)) dut_ext (
    .clk(clk), .reset(reset), .op(op), .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_regdst(x1_regdst), .ex_ULAsrc(x1_ulasrc), .ex_branch(x1_branch), .ex_bne(x1_bne),
    .ex_jump(x1_jump), .ex_ULAop(x1_ulaop), .mem_memread(m1_memread), .mem_memwrite(m1_memwrite),
    .mem_branch(m1_branch), .mem_bne(m1_bne), .wb_memtoreg(w1_memtoreg), .wb_regwrite(w1_regwrite),
    .illegal(i1_illegal), .illegal_cnt(c1_cnt)
  );

  pipelined_main_control #(.EXT(1'b0), .CNTW(8)) dut_base (
    .clk(clk), .reset(reset), .op(op), .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_regdst(x0_regdst), .ex_ULAsrc(x0_ulasrc), .ex_branch(x0_branch), .ex_bne(x0_bne),
    .ex_jump(x0_jump), .ex_ULAop(x0_ulaop), .mem_memread(m0_memread), .mem_memwrite(m0_memwrite),
    .mem_branch(m0_branch), .mem_bne(m0_bne), .wb_memtoreg(w0_memtoreg), .wb_regwrite(w0_regwrite),
    .illegal(i0_illegal), .illegal_cnt(c0_cnt)
  );

  logic [OW-1:0] act1, act0;
  assign act1 = {x1_regdst, x1_ulasrc, x1_branch, x1_bne, x1_jump, x1_ulaop,
                 m1_memread, m1_memwrite, m1_branch, m1_bne, w1_memtoreg, w1_regwrite,
                 i1_illegal, c1_cnt};
  assign act0 = {x0_regdst, x0_ulasrc, x0_branch, x0_bne, x0_jump, 1'b0, x0_ulaop,
                 m0_memread, m0_memwrite, m0_branch, m0_bne, w0_memtoreg, w0_regwrite,
                 i0_illegal, c0_cnt};

  // ---------------- reference model ----------------
  // ex: [11]regdst [10]ULAsrc [9]memtoreg [8]regwrite [7]memread [6]memwrite
  //     [5]branch [4]bne [3]jump [2:0]ULAop
  // mem: [5]memtoreg [4]regwrite [3]memread [2]memwrite [1]branch [0]bne
  logic [11:0] m_ex  [2];
  logic [5:0]  m_mem [2];
  logic [1:0]  m_wb  [2];
  logic        m_ill [2];
  logic [7:0]  m_cnt [2];

  // {ex bundle, illegal}
  function automatic logic [12:0] ref_decode(input logic [5:0] o, input bit ext);
    case (o)
      6'b000000: return 13'b1_0_0_1_0_0_0_0_0_010_0;
      6'b100011: return 13'b0_1_1_1_1_0_0_0_0_000_0;
      6'b101011: return 13'b0_1_0_0_0_1_0_0_0_000_0;
      6'b000100: return 13'b0_0_0_0_0_0_1_0_0_001_0;
      default: ;
    endcase
    if (ext) begin
      case (o)
        6'b000101: return 13'b0_0_0_0_0_0_1_1_0_001_0;
        6'b001000: return 13'b0_1_0_1_0_0_0_0_0_000_0;
        6'b001100: return 13'b0_1_0_1_0_0_0_0_0_011_0;
        6'b001101: return 13'b0_1_0_1_0_0_0_0_0_100_0;
        6'b001010: return 13'b0_1_0_1_0_0_0_0_0_101_0;
        6'b000010: return 13'b0_0_0_0_0_0_0_0_1_000_0;
        default: ;
      endcase
    end
    return 13'b0_0_0_0_0_0_0_0_0_000_1;
  endfunction

  function automatic void model_clear();
    for (int e = 0; e < 2; e++) begin
      m_ex[e] = '0; m_mem[e] = '0; m_wb[e] = '0; m_ill[e] = 1'b0; m_cnt[e] = '0;
    end
  endfunction

  function automatic void model_step(input logic [5:0] o, input logic v, input logic st,
                                     input logic fl);
    logic [12:0] d;
    for (int e = 0; e < 2; e++) begin
      d = ref_decode(o, e == 1);
      m_wb[e]  = m_mem[e][5:4];
      m_mem[e] = fl ? 6'b0 : m_ex[e][9:4];
      m_ill[e] = v && d[0] && !fl && !st;
      if (m_ill[e] && m_cnt[e] != 8'hFF) m_cnt[e] = m_cnt[e] + 8'd1;
      m_ex[e]  = (fl || st || !v || d[0]) ? 12'b0 : d[12:1];
    end
  endfunction

  function automatic logic [OW-1:0] exp_word(input int e);
    return {m_ex[e][11], m_ex[e][10], m_ex[e][5], m_ex[e][4], m_ex[e][3], m_ex[e][2:0],
            m_mem[e][3], m_mem[e][2], m_mem[e][1], m_mem[e][0], m_wb[e][1], m_wb[e][0],
            m_ill[e], m_cnt[e]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ext_outputs", act1, e[W-1:OW]);
      check("base_outputs", act0, e[OW-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [5:0] o, input logic v, input logic st, input logic fl);
    op = o; id_valid = v; stall = st; flush = fl;
    model_step(o, v, st, fl);
    @(posedge clk);
    exp_q.push_back({exp_word(1), exp_word(0)});
    #1;
  endtask

  task automatic issue(input logic [5:0] o);
    step(o, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(6'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1; op = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #1;
    check("async_reset_ext", act1, '0);
    check("async_reset_base", act0, '0);
    model_clear();
    @(posedge clk);
    exp_q.push_back({exp_word(1), exp_word(0)});
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; op = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    model_clear();
    do_reset();

    // in-flight lw/sw/R discarded by a mid-stream reset, then lw latency
    issue(6'b100011); issue(6'b101011); issue(6'b000000);
    do_reset();
    issue(6'b100011); idle(3);

    // back-to-back R, lw, sw, beq
    issue(6'b000000); issue(6'b100011); issue(6'b101011); issue(6'b000100); idle(3);

    // lw followed by a stalled R
    issue(6'b100011); step(6'b000000, 1'b1, 1'b1, 1'b0); idle(3);

    // beq then sw in EX squashed by flush together with stall
    issue(6'b000100); issue(6'b101011); step(6'b100011, 1'b1, 1'b1, 1'b1); idle(3);

    // extended opcodes: legal on the extended instance, illegal on the basic one
    issue(6'b001101); idle(1);
    issue(6'b000101); issue(6'b001000); issue(6'b001100); issue(6'b001010); issue(6'b000010);
    idle(3);

    // illegal suppressed by stall and by flush; invalid lw is a bubble
    step(6'b111111, 1'b1, 1'b1, 1'b0);
    step(6'b111111, 1'b1, 1'b0, 1'b1);
    step(6'b100011, 1'b0, 1'b0, 1'b0);
    issue(6'b110001); idle(2);

    // counter saturation
    repeat (300) issue(6'b111111);
    issue(6'b111111); idle(2);

    do_reset();
    issue(6'b101011); idle(3);

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_main_control.md
# pipelined_main_control

Pipelined successor of the MIPS main control unit. It decodes the ID-stage opcode into a control bundle and carries it through registered ID/EX, EX/MEM and MEM/WB stages. It handles bubble insertion on stall, squashing on flush, and detection and counting of illegal opcodes. An optional extended mode adds I-type ALU, `bne` and `j` support. It sits between the instruction register and the datapath of the MIPS pipeline.

## Interface
- `EXT`, 1 — 1 enables the extended opcodes (`addi`, `andi`, `ori`, `slti`, `bne`, `j`); 0 accepts only R-format, `lw`, `sw` and `beq`.
- `CNTW`, 8 — width of the saturating illegal-opcode counter.
- `ULAOPW`, localparam, `EXT ? 3 : 2` — width of `ULAop`.
- `clk` in 1 — clock, rising edge.
- `reset` in 1 — asynchronous, active-high; clears every register.
- `op` in 6 — opcode of the ID-stage instruction.
- `id_valid` in 1 — `op` is a real instruction this cycle.
- `stall` in 1 — hazard unit: insert a bubble into ID/EX.
- `flush` in 1 — branch taken: squash ID/EX and EX/MEM.
- `ex_regdst`, `ex_ULAsrc`, `ex_branch`, `ex_bne`, `ex_jump` out 1 each — EX-stage controls.
- `ex_ULAop` out `ULAOPW` — ALU operation class.
- `mem_memread`, `mem_memwrite`, `mem_branch`, `mem_bne` out 1 each — MEM-stage controls.
- `wb_memtoreg`, `wb_regwrite` out 1 each — WB-stage controls.
- `illegal` out 1 — one-cycle pulse, aligned with the EX stage.
- `illegal_cnt` out `CNTW` — saturating count of illegal opcodes.

## Operation
- Decode (all unlisted fields 0; `ULAop` codes: add 000, sub 001, funct 010, and 011, or 100, slt 101; when `EXT=0` use the low 2 bits):
  - R 000000: `regdst`=1, `regwrite`=1, `ULAop`=funct.
  - `lw` 100011: `ULAsrc`=1, `memtoreg`=1, `regwrite`=1, `memread`=1, `ULAop`=add.
  - `sw` 101011: `ULAsrc`=1, `memwrite`=1, `ULAop`=add.
  - `beq` 000100: `branch`=1, `ULAop`=sub.
  - Extended opcodes, valid only when `EXT=1`:
    - `bne` 000101: `branch`=1, `bne`=1, `ULAop`=sub.
    - `addi` 001000: `ULAsrc`=1, `regwrite`=1, `ULAop`=add.
    - `andi` 001100: `ULAsrc`=1, `regwrite`=1, `ULAop`=and.
    - `ori` 001101: `ULAsrc`=1, `regwrite`=1, `ULAop`=or.
    - `slti` 001010: `ULAsrc`=1, `regwrite`=1, `ULAop`=slt.
    - `j` 000010: `jump`=1.
- Any other opcode with `id_valid`=1 is illegal.
  - ID/EX loads a bubble.
  - `illegal` pulses.
  - `illegal_cnt` increments and saturates at all-ones.
- Bubble = all control bits 0 and `ULAop`=0.
- Per-edge priority for ID/EX: `flush` > `stall` > (`id_valid`=0 or illegal) → bubble; otherwise the decoded bundle.
- `flush` also loads a bubble into EX/MEM. MEM/WB always advances.
- `stall` does not hold EX/MEM or MEM/WB; downstream stages drain normally.
- `illegal` is suppressed when `flush` or `stall` is set in the same cycle, and the counter does not increment.

## Timing
- Latency from `op` sampled at edge N:
  - `ex_*` valid after edge N.
  - `mem_*` valid after edge N+1.
  - `wb_*` valid after edge N+2.
- Throughput: one instruction per cycle.
- The only combinational path is `op` → decoder → ID/EX D input; there is no combinational input-to-output path.
- Reset: every output is 0 immediately (asynchronous assert); the first bundle can load on the first rising edge after deassert.
- Reset mid-operation discards all in-flight bundles and clears `illegal_cnt`.
- Counter at saturation: holds its value, `illegal` still pulses.

## Structure
- Package `main_control_pkg` holds:
  - opcode localparams;
  - `ULAop` encoding constants;
  - struct `ctrl_t` (`regdst`, `ULAsrc`, `memtoreg`, `regwrite`, `memread`, `memwrite`, `branch`, `bne`, `jump`, `ULAop`);
  - constant `CTRL_BUBBLE`.
- Sub-module `control_decoder`: combinational `op`, `EXT` → `ctrl_t` plus `illegal_op`.
- Top level: three pipeline registers plus the counter.

## Test plan
- Reset asserted mid-stream with `lw`, `sw`, R in flight → all outputs 0 at once; after release, `op`=100011 gives `ex_ULAsrc`=1 at +1, `mem_memread`=1 at +2, `wb_memtoreg`=`wb_regwrite`=1 at +3.
- Back-to-back sequence R, `lw`, `sw`, `beq`, one per cycle → each bundle appears at the correct stage with no cross-contamination; `ex_ULAop` reads 010, 000, 000, 001.
- `lw` then `stall`=1 for one cycle with `op`=R → ID/EX is a bubble while `lw` still reaches `wb_regwrite`=1 on schedule.
- `beq` in EX with `flush`=1 asserted together with `stall`=1 → ID/EX and EX/MEM become bubbles; `mem_memwrite`=0 even when the squashed instruction was `sw`.
- `EXT=1`: `op`=001101 → `ex_ULAop`=100, `ex_ULAsrc`=1. `EXT=0`: same `op` → `illegal`=1, `illegal_cnt`=1, bubble in ID/EX.
- `op`=111111 with `id_valid`=1 for 300 cycles at `CNTW`=8 → `illegal_cnt` saturates at 255; `wb_regwrite` and `mem_memwrite` never assert.
